// File: rtl/tone_meter.sv
// Tone period/amplitude meter: hysteretic rising-crossing detector with a period averaged over 2^AVG_LOG2 cycles.
// Build option: define TONE_METER_PEAK_EN to include the peak-amplitude tracker (otherwise peak is tied to 0).
module tone_meter #(
  parameter int DW       = 10,
  parameter int CW       = 24,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 clear,
  output logic [CW-1:0]        period,
  output logic [DW-1:0]        peak,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int SW = CW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic signed [DW-1:0] HI = DW'(HYST);
  localparam logic signed [DW-1:0] LO = DW'(-HYST);
  localparam logic [NW-1:0] NPER_LAST = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {CMP_UNK = 2'd0, CMP_NEG = 2'd1, CMP_POS = 2'd2} cmp_t;
  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  state_t          state, state_nxt;
  cmp_t            cmp, cmp_nxt, cmp_in;
  logic            rise, done, tmo;
  logic [NW-1:0]   nper;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sum, total;

  always_comb begin
    cmp_in = cmp;
    if (in_data >= HI)      cmp_in = CMP_POS;
    else if (in_data <= LO) cmp_in = CMP_NEG;
  end

  assign rise  = in_valid && (cmp == CMP_NEG) && (cmp_in == CMP_POS);
  assign done  = rise && (state == MEAS) && (nper == NPER_LAST);
  // A completing event resets cnt, so it wins over the saturation check.
  assign tmo   = in_valid && (state == MEAS) && !rise && (cnt == '1);
  assign total = sum + SW'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmp   <= CMP_UNK;
    end else begin
      state <= state_nxt;
      cmp   <= cmp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmp_nxt   = cmp;
    if (clear) begin
      state_nxt = IDLE;
      cmp_nxt   = CMP_UNK;
    end else if (in_valid) begin
      cmp_nxt = cmp_in;
      if (state == IDLE && rise) state_nxt = MEAS;
      if (tmo) begin
        state_nxt = IDLE;
        cmp_nxt   = CMP_UNK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nper       <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (clear) begin
        nper   <= '0;
        locked <= 1'b0;
      end else if (in_valid) begin
        if (state == IDLE) begin
          if (rise) nper <= '0;
        end else if (rise) begin
          if (done) begin
            nper       <= '0;
            period     <= CW'(total >> AVG_LOG2);
            meas_valid <= 1'b1;
            locked     <= 1'b1;
          end else begin
            nper <= nper + NW'(1);
          end
        end else if (tmo) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
        end
      end
    end
  end

  // Window accumulators are always reinitialised on MEAS entry, so they need no reset.
  always_ff @(posedge clk) begin
    if (in_valid && !clear) begin
      if (rise && (state == IDLE || done)) begin
        cnt <= CW'(1);
        sum <= '0;
      end else if (rise) begin
        cnt <= CW'(1);
        sum <= total;
      end else if (state == MEAS && !tmo) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef TONE_METER_PEAK_EN
  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] x);
    logic [DW-1:0] u;
    u = x;
    return x[DW-1] ? (~u + DW'(1)) : u;
  endfunction

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DW-1:0] pk, pk_fold, mag_in;
  assign mag_in  = mag(in_data);
  assign pk_fold = umax(pk, mag_in);

  always_ff @(posedge clk) begin
    if (in_valid && !clear) begin
      if (rise && (state == IDLE || done)) pk <= mag_in;
      else if (state == MEAS && !tmo)      pk <= pk_fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          peak <= '0;
    else if (in_valid && !clear && done) peak <= pk_fold;
  end
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter: triangle tone, alternating-period square, noise, clear, async reset and CW=8 timeout.
module tb_tone_meter;

  localparam int PK_EN =
`ifdef TONE_METER_PEAK_EN
    1;
`else
    0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, in_valid, clear;
  logic signed [9:0] in_data;
  logic [23:0]       period;
  logic [9:0]        peak;
  logic              meas_valid, locked, timeout;
  logic [7:0]        period8;
  logic [9:0]        peak8;
  logic              meas_valid8, locked8, timeout8;

  int n_assert, n_fail, idx, mv_cnt, mv_last, to_cnt, to8_cnt;
  int mv_per[$];

  always #5 clk = ~clk;

  tone_meter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .period(period), .peak(peak), .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  tone_meter #(.CW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .period(period8), .peak(peak8), .meas_valid(meas_valid8), .locked(locked8), .timeout(timeout8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    in_data  = 10'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (meas_valid) begin
      mv_cnt++;
      mv_last = idx;
      mv_per.push_back(int'(period));
    end
    to_cnt  += int'(timeout);
    to8_cnt += int'(timeout8);
    idx++;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idx = 0; mv_cnt = 0; mv_last = -1; to_cnt = 0; to8_cnt = 0;
    mv_per.delete();
  endtask

  // Triangle tone, period 100, amplitude 511; rising crossing at phase 1.
  function automatic int tri_s(input int n);
    int p;
    p = n % 100;
    if (p <= 25)      return 511 * p / 25;
    else if (p <= 75) return 511 * (50 - p) / 25;
    else              return 511 * (p - 100) / 25;
  endfunction

  initial begin
    n_assert = 0; n_fail = 0;
    idx = 0; mv_cnt = 0; mv_last = -1; to_cnt = 0; to8_cnt = 0;
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_period", int'(period), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_locked8", int'(locked8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // tone: events at 101..501 complete the first window, then every 400 samples
    for (int n = 0; n < 1000; n++) begin
      send(tri_s(n));
      if (n == 500) chk("sine_no_early", int'(meas_valid), 0);
      if (n == 501) begin
        chk("sine_meas_valid", int'(meas_valid), 1);
        chk("sine_period", int'(period), 100);
        chk("sine_peak", int'(peak), PK_EN * 511);
        chk("sine_locked", int'(locked), 1);
        chk("sine_period8", int'(period8), 100);
      end
      if (n == 502) chk("sine_strobe_len", int'(meas_valid), 0);
    end
    chk("sine_count", mv_cnt, 2);
    chk("sine_repeat_at", mv_last, 901);
    chk("sine_repeat_period", mv_per[1], 100);

    // clear mid-window; restart needs a NEG first, then 1 event plus 4 periods
    clear = 1'b1;
    send(tri_s(1000));
    clear = 1'b0;
    chk("clr_locked", int'(locked), 0);
    chk("clr_period_hold", int'(period), 100);
    chk("clr_peak_hold", int'(peak), PK_EN * 511);
    chk("clr_meas_valid", int'(meas_valid), 0);
    for (int n = 1001; n <= 1500; n++) send(tri_s(n));
    chk("clr_no_result", mv_cnt, 2);
    send(tri_s(1501));
    chk("clr_result", int'(meas_valid), 1);
    chk("clr_period", int'(period), 100);
    chk("clr_relock", int'(locked), 1);
    for (int n = 1502; n < 1550; n++) send(tri_s(n));

    // asynchronous reset mid-window, observed before any clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_peak", int'(peak), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_period8", int'(period8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idx = 0; mv_cnt = 0; mv_per.delete();

    // square +/-300 with periods alternating 99/101
    repeat (10) send(-300);
    for (int k = 0; k < 9; k++) begin
      repeat (50) send(300);
      repeat ((k % 2 == 0) ? 49 : 51) send(-300);
    end
    chk("sq_count", mv_cnt, 2);
    chk("sq_period0", mv_per[0], 100);
    chk("sq_period1", mv_per[1], 100);
    chk("sq_peak", int'(peak), PK_EN * 300);
    chk("sq_locked", int'(locked), 1);

    // in-band noise never forms an event
    do_reset();
    for (int i = 0; i < 300; i++) send((i % 11) - 5);
    chk("noise_meas_valid", mv_cnt, 0);
    chk("noise_locked", int'(locked), 0);
    chk("noise_timeout", to_cnt + to8_cnt, 0);

    // CW=8: lock, then hold +100 until the counter saturates
    do_reset();
    repeat (10) send(-300);
    repeat (4) begin
      repeat (50) send(300);
      repeat (50) send(-300);
    end
    send(100);
    chk("to_pre_meas8", int'(meas_valid8), 1);
    chk("to_pre_locked8", int'(locked8), 1);
    chk("to_pre_period8", int'(period8), 100);
    repeat (254) send(100);
    chk("to_not_early", to8_cnt, 0);
    send(100);
    chk("to_pulse", int'(timeout8), 1);
    chk("to_unlock", int'(locked8), 0);
    chk("to_no_meas", int'(meas_valid8), 0);
    chk("to_period_hold", int'(period8), 100);
    send(100);
    chk("to_strobe_len", int'(timeout8), 0);
    repeat (300) send(100);
    chk("to_idle_no_repeat", to8_cnt, 1);
    chk("to_wide_none", to_cnt, 0);
    chk("to_wide_locked", int'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
